mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares one single-ported memory bus between the CPU's instruction-fetch port and its data (load/store) port.
- Accepts one request per requester under a req/ack handshake.
- Grants by a selectable policy and drives a registered request onto the memory bus.
- Returns read data with a one-cycle ack pulse, and aborts hung memory transactions with a timeout error.
- Sits between the cpu top level and the external memory model; the core stalls on its requester's req-without-ack.

Parameters:
AW, 32, address width
DW, 32, data width
RR, 0, arbitration policy: 0 = data port fixed priority, 1 = round-robin on last grant
TIMEOUT, 16, cycles in BUSY before abort; 0 disables the timeout

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
i_req  in  1  fetch request; held high until i_ack
i_addr  in  AW  fetch address
i_rdata  out  DW  fetch read data, valid with i_ack
i_ack  out  1  one-cycle fetch completion pulse
d_req  in  1  data request; held high until d_ack
d_we  in  1  1 = store
d_size  in  3  access size (funct3 encoding)
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_rdata  out  DW  load data, valid with d_ack
d_ack  out  1  one-cycle data completion pulse
err  out  1  pulses with the ack of a timed-out transaction
m_req  out  1  memory request, held until m_ack
m_we  out  1  memory write enable
m_size  out  3  memory access size
m_addr  out  AW  memory address
m_wdata  out  DW  memory write data
m_rdata  in  DW  memory read data, valid with m_ack
m_ack  in  1  memory completion, single cycle

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; all outputs 0; last-grant pointer = fetch; timeout counter 0. This applies mid-transaction as well: m_req drops immediately and the in-flight access is discarded with no ack.
- FSM states: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE:
  - Sample i_req/d_req.
  - Grant when RR=0: d_req wins.
  - Grant when RR=1: if both requesters are pending, the one not granted last wins; a single requester wins alone.
  - On grant: register the address, we, size and wdata into the m_* registers; m_req=1 next cycle; go to BUSY_I or BUSY_D.
  - Fetch grants force m_we=0, m_size=3'b010, m_wdata=0.
- BUSY_x:
  - m_* outputs stay stable.
  - On m_ack: capture m_rdata into the granted requester's rdata register; m_req=0; go to RESP.
  - Timeout counter increments each BUSY cycle. If the counter reaches TIMEOUT-1 with no m_ack (TIMEOUT>0): m_req=0; rdata register = 0; set the err flag; go to RESP. On that cycle the abort has priority over m_ack.
- RESP (one cycle):
  - Granted requester's ack=1 with its registered rdata; err=1 if the transaction was aborted.
  - Update the last-grant pointer; clear the counter; go to IDLE.
  - Requests are not sampled in RESP, so a requester still holding req in its ack cycle is not re-granted.
- Latency: request sampled in IDLE at cycle 0 → m_req at cycle 1 → m_ack at cycle k≥1 → ack at cycle k+1. With a zero-wait memory, back-to-back throughput is one transaction per 3 cycles.
- m_ack outside BUSY is ignored.
- Store: d_rdata is undefined-free and returns m_rdata as captured; software ignores it.
- i_rdata/d_rdata hold their value until the next ack to the same port.
- A requester changing its address or data while its req is high and not yet granted gets the value sampled at grant.
- Only one outstanding memory transaction exists at any time; no buffering beyond one request.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum {IDLE, BUSY_I, BUSY_D, RESP}
  - grant enum {GNT_I, GNT_D}
  - constant SIZE_WORD=3'b010
- Sub-module mem_arb_timer: a saturating counter with clear/enable inputs and an expire output. It is parameterized by TIMEOUT and ties expire=0 when TIMEOUT=0.

Test Plan:
- Single fetch: i_req=1, i_addr=0x100; memory acks 2 cycles after m_req with 0x00500093 → m_addr=0x100, m_we=0; i_ack pulses once with i_rdata=0x00500093; err=0.
- Simultaneous, RR=0: i_req and d_req rise together, d_addr=0x2000 load → data is granted first (m_addr=0x2000); fetch is granted in the IDLE cycle after d_ack.
- Round-robin, RR=1: both requesters held continuously for 4 transactions → grant order D, I, D, I starting from reset pointer=fetch (first pick is data).
- Store: d_we=1, d_size=3'b000, d_addr=0x3, d_wdata=0xAB → m_we=1, m_size=0, m_wdata=0xAB stable until m_ack; d_ack one cycle later.
- Timeout, TIMEOUT=16: m_ack never asserted → m_req drops after 16 BUSY cycles; next cycle i_ack=1, err=1, i_rdata=0; the arbiter then serves the next request normally.
- Reset mid-op: reset=0 during BUSY_D → m_req=0 asynchronously; no d_ack after release; next d_req is granted from IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the instruction/data memory bus arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_t;

  // Fetches are always full-word reads (funct3 LW encoding).
  localparam logic [2:0] SIZE_WORD = 3'b010;

  // Winner among pending requesters; only meaningful when at least one is pending.
  // Round-robin hands a tie to whichever port was not served last, otherwise data wins.
  function automatic gnt_t arb_pick(input logic rr, input logic ireq,
                                    input logic dreq, input gnt_t last);
    if (!ireq) return GNT_D;
    if (!dreq) return GNT_I;
    if (!rr) return GNT_D;
    return (last == GNT_I) ? GNT_D : GNT_I;
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Saturating BUSY-cycle counter; expire flags the last cycle a transaction may wait.
module mem_arb_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  if (TIMEOUT == 0) begin : g_off
    // Timeout disabled: the arbiter waits on the memory indefinitely.
    logic unused_tie;
    assign unused_tie = ^{clk, reset, clr, en};
    assign expire     = 1'b0;
  end else begin : g_on
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIM = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // Count enabled cycles, holding at the limit so it can never wrap.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt <= '0;
      end else if (clr) begin
        cnt <= '0;
      end else if (en && (cnt != LIM)) begin
        cnt <= cnt + 1'b1;
      end
    end

    assign expire = en && (cnt == LIM);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter in front of a single-ported memory bus.
// One transaction in flight at a time: IDLE grants, BUSY waits for m_ack or the
// timeout, RESP returns a one-cycle ack to the port that was served.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int RR      = 0,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [2:0]    d_size,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          err,
  output logic          m_req,
  output logic          m_we,
  output logic [2:0]    m_size,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack
);

  state_t state;
  gnt_t   gnt;
  gnt_t   last;
  gnt_t   pick;
  logic   busy;
  logic   expire;

  assign busy = (state == BUSY_I) || (state == BUSY_D);
  assign pick = arb_pick(RR != 0, i_req, d_req, last);

  mem_arb_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (!busy),
    .en    (busy),
    .expire(expire)
  );

  // Arbitration FSM with all bus and response outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      gnt     <= GNT_I;
      last    <= GNT_I;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_size  <= '0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      err     <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            m_req <= 1'b1;
            gnt   <= pick;
            if (pick == GNT_D) begin
              m_we    <= d_we;
              m_size  <= d_size;
              m_addr  <= d_addr;
              m_wdata <= d_wdata;
              state   <= BUSY_D;
            end else begin
              m_we    <= 1'b0;
              m_size  <= SIZE_WORD;
              m_addr  <= i_addr;
              m_wdata <= '0;
              state   <= BUSY_I;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          // The abort wins over a coincident m_ack so a late reply is never mixed in.
          if (expire || m_ack) begin
            m_req <= 1'b0;
            err   <= expire;
            state <= RESP;
            if (gnt == GNT_D) begin
              d_ack   <= 1'b1;
              d_rdata <= expire ? '0 : m_rdata;
            end else begin
              i_ack   <= 1'b1;
              i_rdata <= expire ? '0 : m_rdata;
            end
          end
        end
        RESP: begin
          last  <= gnt;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a fixed-priority and a round-robin instance, each with
// requester agents, a latency-programmable memory responder and a reference model.
module tb_mem_arbiter;

  localparam int TO    = 16;
  localparam int NEVER = 1000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       i_req, i_ack, d_req, d_we, d_ack, err, m_req, m_we, m_ack;
  logic [1:0][2:0]  d_size, m_size;
  logic [1:0][31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, m_addr, m_wdata, m_rdata;

  mem_arbiter #(.AW(32), .DW(32), .RR(0), .TIMEOUT(TO)) u_fp (
    .clk(clk), .reset(reset),
    .i_req(i_req[0]), .i_addr(i_addr[0]), .i_rdata(i_rdata[0]), .i_ack(i_ack[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_size(d_size[0]), .d_addr(d_addr[0]),
    .d_wdata(d_wdata[0]), .d_rdata(d_rdata[0]), .d_ack(d_ack[0]), .err(err[0]),
    .m_req(m_req[0]), .m_we(m_we[0]), .m_size(m_size[0]), .m_addr(m_addr[0]),
    .m_wdata(m_wdata[0]), .m_rdata(m_rdata[0]), .m_ack(m_ack[0])
  );

  mem_arbiter #(.AW(32), .DW(32), .RR(1), .TIMEOUT(TO)) u_rr (
    .clk(clk), .reset(reset),
    .i_req(i_req[1]), .i_addr(i_addr[1]), .i_rdata(i_rdata[1]), .i_ack(i_ack[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_size(d_size[1]), .d_addr(d_addr[1]),
    .d_wdata(d_wdata[1]), .d_rdata(d_rdata[1]), .d_ack(d_ack[1]), .err(err[1]),
    .m_req(m_req[1]), .m_we(m_we[1]), .m_size(m_size[1]), .m_addr(m_addr[1]),
    .m_wdata(m_wdata[1]), .m_rdata(m_rdata[1]), .m_ack(m_ack[1])
  );

  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } item_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [2:0]  size;
    logic [31:0] wdata;
    int          cyc;
  } glog_t;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } alog_t;

  item_t iq[2][$];
  item_t dq[2][$];
  glog_t glog[2][$];
  alog_t alog[2][$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Stimulus / responder state
  int   lat[2];
  int   mcnt[2];
  int   mreq_len[2];
  bit   stray[2];
  bit   wiggle;
  bit   prev_mreq[2];
  int   ipres_cyc[2];
  int   rr_pol[2];

  // Reference model state: who owns the bus, whether this is the reply cycle
  int          own[2];
  bit          inresp[2];
  int          wcnt[2];
  int          last[2];
  logic        e_mreq[2], e_mwe[2], e_iack[2], e_dack[2], e_err[2];
  logic [2:0]  e_msize[2];
  logic [31:0] e_maddr[2], e_mwdata[2], e_irdata[2], e_drdata[2];

  function automatic item_t mk(input logic we, input logic [2:0] size,
                               input logic [31:0] addr, input logic [31:0] wdata);
    item_t it;
    it.we = we; it.size = size; it.addr = addr; it.wdata = wdata;
    return it;
  endfunction

  function automatic logic [31:0] memdata(input logic [31:0] a);
    if (a == 32'h100) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input int u, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL u%0d %s actual=%h required=%h (cycle %0d)", u, name, act, exp, cyc);
    end
  endtask

  task automatic model_reset(input int u);
    own[u] = -1; inresp[u] = 0; wcnt[u] = 0; last[u] = 0;
    e_mreq[u] = 0; e_mwe[u] = 0; e_msize[u] = 0; e_maddr[u] = 0; e_mwdata[u] = 0;
    e_iack[u] = 0; e_dack[u] = 0; e_err[u] = 0; e_irdata[u] = 0; e_drdata[u] = 0;
  endtask

  task automatic compare(input int u);
    chk(u, "m_req", m_req[u], e_mreq[u]);
    chk(u, "i_ack", i_ack[u], e_iack[u]);
    chk(u, "d_ack", d_ack[u], e_dack[u]);
    chk(u, "err", err[u], e_err[u]);
    chk(u, "i_rdata", i_rdata[u], e_irdata[u]);
    chk(u, "d_rdata", d_rdata[u], e_drdata[u]);
    if (e_mreq[u]) begin
      chk(u, "m_addr", m_addr[u], e_maddr[u]);
      chk(u, "m_we", m_we[u], e_mwe[u]);
      chk(u, "m_size", m_size[u], e_msize[u]);
      chk(u, "m_wdata", m_wdata[u], e_mwdata[u]);
    end
  endtask

  task automatic agents(input int u);
    item_t it;
    if (i_req[u] && i_ack[u]) i_req[u] = 1'b0;
    if (!i_req[u] && iq[u].size() > 0) begin
      it = iq[u].pop_front();
      i_req[u] = 1'b1; i_addr[u] = it.addr; ipres_cyc[u] = cyc;
    end
    if (d_req[u] && d_ack[u]) d_req[u] = 1'b0;
    if (!d_req[u] && dq[u].size() > 0) begin
      it = dq[u].pop_front();
      d_req[u] = 1'b1; d_we[u] = it.we; d_size[u] = it.size;
      d_addr[u] = it.addr; d_wdata[u] = it.wdata;
    end else if (wiggle && d_req[u]) begin
      d_addr[u] = $urandom; d_wdata[u] = $urandom;
    end
  endtask

  task automatic responder(input int u);
    m_ack[u] = 1'b0;
    m_rdata[u] = $urandom;
    if (m_req[u]) begin
      if (mcnt[u] == lat[u]) begin
        m_ack[u] = 1'b1; m_rdata[u] = memdata(m_addr[u]);
      end
      mcnt[u]++;
    end else begin
      if (mcnt[u] != 0) mreq_len[u] = mcnt[u];
      mcnt[u] = 0;
      if (stray[u]) begin
        m_ack[u] = 1'b1; stray[u] = 0;
      end
    end
  endtask

  // Advance the model across the coming clock edge using the inputs now driven.
  task automatic model_step(input int u);
    logic [31:0] rd;
    bit          done;
    e_iack[u] = 0; e_dack[u] = 0; e_err[u] = 0;
    if (inresp[u]) begin
      inresp[u] = 0; last[u] = own[u]; own[u] = -1;
    end else if (own[u] < 0) begin
      if (i_req[u] || d_req[u]) begin
        if (!i_req[u]) own[u] = 1;
        else if (!d_req[u]) own[u] = 0;
        else if (rr_pol[u] == 0) own[u] = 1;
        else own[u] = (last[u] == 0) ? 1 : 0;
        wcnt[u] = 0; e_mreq[u] = 1;
        if (own[u] == 1) begin
          e_mwe[u] = d_we[u]; e_msize[u] = d_size[u];
          e_maddr[u] = d_addr[u]; e_mwdata[u] = d_wdata[u];
        end else begin
          e_mwe[u] = 0; e_msize[u] = 3'b010; e_maddr[u] = i_addr[u]; e_mwdata[u] = 0;
        end
      end
    end else begin
      done = 0; rd = 0;
      if (wcnt[u] == TO - 1) begin
        done = 1; e_err[u] = 1;
      end else if (m_ack[u]) begin
        done = 1; rd = m_rdata[u];
      end else begin
        wcnt[u]++;
      end
      if (done) begin
        e_mreq[u] = 0; inresp[u] = 1;
        if (own[u] == 0) begin e_iack[u] = 1; e_irdata[u] = rd; end
        else begin e_dack[u] = 1; e_drdata[u] = rd; end
      end
    end
  endtask

  task automatic unit_cycle(input int u);
    alog_t a;
    glog_t g;
    if (!reset) begin
      model_reset(u);
      compare(u);
      i_req[u] = 0; d_req[u] = 0; m_ack[u] = 0; mcnt[u] = 0; prev_mreq[u] = 0;
      return;
    end
    compare(u);
    if (m_req[u] && !prev_mreq[u]) begin
      g.addr = m_addr[u]; g.we = m_we[u]; g.size = m_size[u]; g.wdata = m_wdata[u]; g.cyc = cyc;
      glog[u].push_back(g);
    end
    prev_mreq[u] = m_req[u];
    if (i_ack[u]) begin
      a.port = 0; a.rdata = i_rdata[u]; a.err = err[u]; a.cyc = cyc; alog[u].push_back(a);
    end
    if (d_ack[u]) begin
      a.port = 1; a.rdata = d_rdata[u]; a.err = err[u]; a.cyc = cyc; alog[u].push_back(a);
    end
    agents(u);
    responder(u);
    model_step(u);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      for (int u = 0; u < 2; u++) unit_cycle(u);
    end
  end

  task automatic wait_done(input int u, input int budget);
    int n = 0;
    while (!(iq[u].size() == 0 && dq[u].size() == 0 && !i_req[u] && !d_req[u] &&
             own[u] < 0 && !inresp[u]) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL u%0d wait_done timed out after %0d cycles", u, budget);
    end
  endtask

  task automatic clear_logs();
    for (int u = 0; u < 2; u++) begin
      glog[u].delete(); alog[u].delete();
    end
  endtask

  initial begin
    int n;
    rr_pol[0] = 0; rr_pol[1] = 1;
    wiggle = 0;
    for (int u = 0; u < 2; u++) begin
      i_req[u] = 0; i_addr[u] = 0; d_req[u] = 0; d_we[u] = 0; d_size[u] = 0;
      d_addr[u] = 0; d_wdata[u] = 0; m_ack[u] = 0; m_rdata[u] = 0;
      lat[u] = 0; mcnt[u] = 0; mreq_len[u] = 0; stray[u] = 0; prev_mreq[u] = 0;
      ipres_cyc[u] = 0;
      model_reset(u);
    end
    repeat (3) @(negedge clk);
    #1;
    chk(0, "reset m_req", m_req[0], 0);
    chk(0, "reset i_rdata", i_rdata[0], 0);
    chk(1, "reset d_ack", d_ack[1], 0);
    #1 reset = 1'b1;

    // Single fetch on the fixed-priority unit; round-robin ordering on the other.
    lat[0] = 2; lat[1] = 0;
    iq[0].push_back(mk(0, 3'b010, 32'h100, 0));
    dq[1].push_back(mk(0, 3'b010, 32'h10, 0));
    dq[1].push_back(mk(0, 3'b010, 32'h14, 0));
    iq[1].push_back(mk(0, 3'b010, 32'h20, 0));
    iq[1].push_back(mk(0, 3'b010, 32'h24, 0));
    wait_done(0, 40);
    wait_done(1, 40);
    chk(0, "fetch grants", glog[0].size(), 1);
    chk(0, "fetch m_addr", glog[0][0].addr, 32'h100);
    chk(0, "fetch m_we", glog[0][0].we, 0);
    chk(0, "fetch m_size", glog[0][0].size, 3'b010);
    chk(0, "fetch acks", alog[0].size(), 1);
    chk(0, "fetch port", alog[0][0].port, 0);
    chk(0, "fetch rdata", alog[0][0].rdata, 32'h0050_0093);
    chk(0, "fetch err", alog[0][0].err, 0);
    chk(0, "fetch latency", alog[0][0].cyc - ipres_cyc[0], 4);
    chk(1, "rr grants", glog[1].size(), 4);
    chk(1, "rr grant0", glog[1][0].addr, 32'h10);
    chk(1, "rr grant1", glog[1][1].addr, 32'h20);
    chk(1, "rr grant2", glog[1][2].addr, 32'h14);
    chk(1, "rr grant3", glog[1][3].addr, 32'h24);
    clear_logs();

    // Simultaneous requests under fixed priority, with a stray m_ack beforehand.
    stray[0] = 1;
    repeat (2) @(negedge clk);
    lat[0] = 0;
    iq[0].push_back(mk(0, 3'b010, 32'h400, 0));
    dq[0].push_back(mk(0, 3'b010, 32'h2000, 0));
    wait_done(0, 40);
    chk(0, "simul grants", glog[0].size(), 2);
    chk(0, "simul first", glog[0][0].addr, 32'h2000);
    chk(0, "simul second", glog[0][1].addr, 32'h400);
    chk(0, "simul ack0 port", alog[0][0].port, 1);
    chk(0, "simul fetch gap", glog[0][1].cyc - alog[0][0].cyc, 2);
    clear_logs();

    // Byte store with a three-cycle memory.
    lat[0] = 3;
    dq[0].push_back(mk(1, 3'b000, 32'h3, 32'hAB));
    wait_done(0, 40);
    chk(0, "store m_we", glog[0][0].we, 1);
    chk(0, "store m_size", glog[0][0].size, 3'b000);
    chk(0, "store m_addr", glog[0][0].addr, 32'h3);
    chk(0, "store m_wdata", glog[0][0].wdata, 32'hAB);
    chk(0, "store ack delay", alog[0][0].cyc - glog[0][0].cyc, 4);
    chk(0, "store ack port", alog[0][0].port, 1);
    clear_logs();

    // Hung memory: abort with err, then a normal fetch.
    lat[0] = NEVER;
    iq[0].push_back(mk(0, 3'b010, 32'h500, 0));
    wait_done(0, 60);
    chk(0, "timeout m_req len", mreq_len[0], 16);
    chk(0, "timeout port", alog[0][0].port, 0);
    chk(0, "timeout rdata", alog[0][0].rdata, 0);
    chk(0, "timeout err", alog[0][0].err, 1);
    lat[0] = 1;
    iq[0].push_back(mk(0, 3'b010, 32'h100, 0));
    wait_done(0, 40);
    chk(0, "after timeout rdata", alog[0][1].rdata, 32'h0050_0093);
    chk(0, "after timeout err", alog[0][1].err, 0);
    clear_logs();

    // Data inputs churn while pending; the model tracks the value taken at grant.
    wiggle = 1; lat[0] = 2; lat[1] = 1;
    for (int k = 0; k < 3; k++) begin
      dq[0].push_back(mk(k[0], 3'b001, 32'h40 + k, 32'h11 * k));
      iq[0].push_back(mk(0, 3'b010, 32'h80 + 4 * k, 0));
      dq[1].push_back(mk(1, 3'b010, 32'h90 + k, 32'h22 * k));
      iq[1].push_back(mk(0, 3'b010, 32'hA0 + 4 * k, 0));
    end
    wait_done(0, 80);
    wait_done(1, 80);
    wiggle = 0;
    chk(0, "churn acks", alog[0].size(), 6);
    chk(1, "churn acks", alog[1].size(), 6);
    clear_logs();

    // Asynchronous reset in the middle of a data transaction.
    lat[0] = NEVER;
    dq[0].push_back(mk(0, 3'b010, 32'h600, 0));
    n = 0;
    while (!m_req[0] && n < 20) begin @(negedge clk); n++; end
    chk(0, "mid-op m_req seen", m_req[0], 1);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk(0, "async m_req drop", m_req[0], 0);
    chk(0, "async d_ack", d_ack[0], 0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    lat[0] = 0;
    n = alog[0].size();
    chk(0, "no ack across reset", n, 0);
    dq[0].push_back(mk(0, 3'b010, 32'h700, 0));
    wait_done(0, 40);
    chk(0, "post-reset acks", alog[0].size(), 1);
    chk(0, "post-reset grant", glog[0][glog[0].size() - 1].addr, 32'h700);
    chk(0, "post-reset rdata", alog[0][0].rdata, memdata(32'h700));

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
